// File: rtl/srec_loader_if.sv
// srec_loader_if: character stream in, byte write strobes out
interface srec_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  modport master (output rx_data, rx_valid, input rx_ready, mem_addr, mem_data, mem_we);
  modport slave (input rx_data, rx_valid, output rx_ready, mem_addr, mem_data, mem_we);
endinterface

// File: rtl/srec_loader.sv
// srec_loader: S19 record parser writing program memory; SREC_LOWERCASE_EN also accepts 's' and 'a'-'f'
module srec_loader #(
  parameter int ADDR_W = 16,
  parameter int LOAD_OFFSET = 0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  srec_loader_if.slave bus,
  output logic [15:0] start_addr,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);
  typedef enum logic [2:0] {IDLE, TYPE, HEX_HI, HEX_LO, DONE, ERR} state_t;
  state_t            state;
  logic [1:0]        rtype;
  logic [3:0]        hi, nib;
  logic [7:0]        c, b, idx, count, sum, addr_hi;
  logic [15:0]       rec_addr;
  logic [ADDR_W-1:0] wptr;
  logic              dig, lc, is_hex, is_s, is_ws;
  logic [1:0]        ec;
  assign c = bus.rx_data;
  assign dig = c >= 8'h30 && c <= 8'h39;
`ifdef SREC_LOWERCASE_EN
  assign lc = c >= 8'h61 && c <= 8'h66;
  assign is_s = c == 8'h53 || c == 8'h73;
`else
  assign lc = 1'b0;
  assign is_s = c == 8'h53;
`endif
  assign is_hex = dig || lc || (c >= 8'h41 && c <= 8'h46);
  // letters 'A'/'a' have low nibble 1, so adding 9 yields 10..15
  assign nib = dig ? c[3:0] : c[3:0] + 4'd9;
  assign b = {hi, nib};
  assign is_ws = c == 8'h0A || c == 8'h0D || c == 8'h20;
  // error cause raised by the character currently offered; 0 means it is legal
  always_comb begin
    ec = state == IDLE ? (is_s || is_ws ? 2'd0 : 2'd1)
       : state == TYPE ? (c == 8'h30 || c == 8'h31 || c == 8'h39 ? 2'd0 : 2'd3)
       : state == HEX_HI ? (is_hex ? 2'd0 : 2'd1)
       : state == HEX_LO ? (!is_hex ? 2'd1
                          : idx == 8'd0 && (b < 8'd3 || (rtype == 2'd2 && b != 8'd3)) ? 2'd3
                          : idx != 8'd0 && idx == count && b != ~sum ? 2'd2 : 2'd0)
       : 2'd0;
  end
  // record FSM; data bytes of S1 records are written as soon as they complete
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      rtype        <= 2'd0;
      hi           <= 4'd0;
      idx          <= 8'd0;
      count        <= 8'd0;
      sum          <= 8'd0;
      addr_hi      <= 8'd0;
      rec_addr     <= 16'd0;
      wptr         <= '0;
      bus.rx_ready <= 1'b1;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= 8'd0;
      start_addr   <= 16'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) begin
        if (ec != 2'd0) begin
          state        <= ERR;
          error        <= 1'b1;
          err_code     <= ec;
          bus.rx_ready <= 1'b0;
        end else begin
          case (state)
            IDLE: if (is_s) state <= TYPE;
            TYPE: begin
              rtype <= c == 8'h39 ? 2'd2 : {1'b0, c[0]};
              idx   <= 8'd0;
              sum   <= 8'd0;
              state <= HEX_HI;
            end
            HEX_HI: begin
              hi    <= nib;
              state <= HEX_LO;
            end
            HEX_LO: begin
              state <= HEX_HI;
              idx   <= idx + 8'd1;
              sum   <= sum + b;
              if (idx == 8'd0) count <= b;
              else if (idx == count) begin
                state <= rtype == 2'd2 ? DONE : IDLE;
                if (rtype == 2'd2) begin
                  start_addr   <= rec_addr;
                  done         <= 1'b1;
                  bus.rx_ready <= 1'b0;
                end
              end else if (idx == 8'd1) addr_hi <= b;
              else if (idx == 8'd2) begin
                rec_addr <= {addr_hi, b};
                wptr     <= ADDR_W'({addr_hi, b}) + ADDR_W'(LOAD_OFFSET);
              end else if (rtype == 2'd1) begin
                bus.mem_we   <= 1'b1;
                bus.mem_addr <= wptr;
                bus.mem_data <= b;
                wptr         <= wptr + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule
